// File: rtl/bnn_pkg.sv
// Shared types and width helpers for the sequential BNN inference engine.
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HID  = 2'd1,
    CLS  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Width of a popcount/score over n bits (holds 0..n).
  function automatic int sum_bits(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of an index over n entries, never narrower than one bit.
  function automatic int cidx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bnn_seq_infer_hs_if.sv
// Start/done sample-feed handshake between a streaming driver and the engine.
interface bnn_seq_infer_hs_if
  import bnn_pkg::*;
#(
  parameter int FEAT_CNT  = 16,
  parameter int FEAT_BITS = 4,
  parameter int CLASS_CNT = 10
);

  logic                              start;
  logic [FEAT_BITS*FEAT_CNT-1:0]     features;
  logic                              busy;
  logic                              done;
  logic [cidx_bits(CLASS_CNT)-1:0]   prediction;

  modport master (
    output start,
    output features,
    input  busy,
    input  done,
    input  prediction
  );

  modport slave (
    input  start,
    input  features,
    output busy,
    output done,
    output prediction
  );

endinterface

// File: rtl/bnn_popcount.sv
// Combinational popcount of an XNOR agreement word.
module bnn_popcount #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]             word,
  output logic [$clog2(WIDTH+1)-1:0]   count
);

  localparam int CW = $clog2(WIDTH + 1);

  // Sum the set bits of the word.
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(word[i]);
    end
  end

endmodule

// File: rtl/bnn_seq_infer_hs.sv
// Sequential binarized neural network: one hidden neuron per cycle, then one
// class score per cycle with a running argmax, behind a start/done handshake.
//
// state | meaning
// IDLE  | waiting for start; features are binarized and latched on accept
// HID   | evaluating hidden neuron idx (HIDDEN_CNT cycles)
// CLS   | scoring class idx and updating the running argmax (CLASS_CNT cycles)
// DONE  | one cycle; the registered done pulse and prediction follow it
module bnn_seq_infer_hs
  import bnn_pkg::*;
#(
  parameter int FEAT_CNT    = 16,
  parameter int FEAT_BITS   = 4,
  parameter int HIDDEN_CNT  = 40,
  parameter int CLASS_CNT   = 10,
  parameter int FEAT_THRESH = 8,
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  W1 = '0,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2 = '0
) (
  input  logic               clk,
  input  logic               rst,
  bnn_seq_infer_hs_if.slave  bus
);

  localparam int IDX_W  = cidx_bits((HIDDEN_CNT > CLASS_CNT) ? HIDDEN_CNT : CLASS_CNT);
  localparam int CIDX_W = cidx_bits(CLASS_CNT);
  localparam int FSUM_W = sum_bits(FEAT_CNT);
  localparam int SUM_W  = sum_bits(HIDDEN_CNT);

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [FEAT_CNT-1:0] fbits, fbits_in, w1_row;
  logic [HIDDEN_CNT-1:0] hbits, w2_row;
  logic [FSUM_W-1:0]   hid_pc;
  logic [SUM_W-1:0]    score, best_score;
  logic [CIDX_W-1:0]   best, cls_idx, pred_q;
  logic                hid_last, cls_last, busy_c, done_nxt, done_q;

  // Binarize the incoming feature vector (unsigned threshold compare).
  always_comb begin
    fbits_in = '0;
    for (int i = 0; i < FEAT_CNT; i++) begin
      fbits_in[i] = int'(bus.features[i*FEAT_BITS +: FEAT_BITS]) >= FEAT_THRESH;
    end
  end

  // Weight-row selection; the class row index is forced to 0 outside the
  // class range so the W2 select never leaves the parameter during HID.
  always_comb begin
    cls_idx = (idx < IDX_W'(CLASS_CNT)) ? CIDX_W'(idx) : '0;
    w1_row  = W1[int'(idx)*FEAT_CNT +: FEAT_CNT];
    w2_row  = W2[int'(cls_idx)*HIDDEN_CNT +: HIDDEN_CNT];
  end

  bnn_popcount #(.WIDTH(FEAT_CNT)) u_pc_hid (
    .word  (~(fbits ^ w1_row)),
    .count (hid_pc)
  );

  bnn_popcount #(.WIDTH(HIDDEN_CNT)) u_pc_cls (
    .word  (~(hbits ^ w2_row)),
    .count (score)
  );

  assign hid_last = (idx == IDX_W'(HIDDEN_CNT - 1));
  assign cls_last = (idx == IDX_W'(CLASS_CNT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start outside IDLE is simply dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = HID;
      HID:     if (hid_last)  state_nxt = CLS;
      CLS:     if (cls_last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy_c   = (state != IDLE);
    done_nxt = (state == DONE);
  end

  // Datapath: feature latch, hidden vector, layer index and running argmax.
  always_ff @(posedge clk) begin
    if (rst) begin
      fbits      <= '0;
      hbits      <= '0;
      idx        <= '0;
      best       <= '0;
      best_score <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            fbits <= fbits_in;
            hbits <= '0;
            idx   <= '0;
          end
        end
        HID: begin
          hbits[idx] <= (2 * int'(hid_pc)) >= FEAT_CNT;
          if (hid_last) begin
            idx        <= '0;
            best       <= '0;
            best_score <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        CLS: begin
          // Class 0 seeds the argmax; strict compare keeps the lowest index on ties.
          if (idx == '0 || score > best_score) begin
            best       <= cls_idx;
            best_score <= score;
          end
          idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered done pulse and held prediction.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      pred_q <= '0;
    end else begin
      done_q <= done_nxt;
      if (done_nxt) pred_q <= best;
    end
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_q;
  assign bus.prediction = pred_q;

endmodule

// File: tb/tb_bnn_seq_infer_hs.sv
// Bench for bnn_seq_infer_hs: scoreboard of expected predictions pushed on
// accept and checked (value and latency) when done pulses.
module tb_bnn_seq_infer_hs;

  localparam int FC = 16;
  localparam int FB = 4;
  localparam int HC = 40;
  localparam int CC = 10;
  localparam int LAT = HC + CC + 1;
  localparam int PERIOD = HC + CC + 2;
  localparam logic [HC*FC-1:0] W1_T = '1;
  localparam logic [CC*HC-1:0] W2_T = {{(6*HC){1'b0}}, {HC{1'b1}}, {(3*HC){1'b0}}};
  localparam logic [FC*FB-1:0] ALL_F = '1;
  localparam logic [FC*FB-1:0] ALL_0 = '0;

  typedef struct {
    logic [3:0] pred;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_done = 0;
  exp_t sb_q[$];

  bnn_seq_infer_hs_if #(.FEAT_CNT(FC), .FEAT_BITS(FB), .CLASS_CNT(CC)) bus ();

  bnn_seq_infer_hs #(
    .FEAT_CNT(FC), .FEAT_BITS(FB), .HIDDEN_CNT(HC), .CLASS_CNT(CC),
    .FEAT_THRESH(8), .W1(W1_T), .W2(W2_T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model of the whole inference.
  function automatic logic [3:0] model(input logic [FC*FB-1:0] f);
    logic [FC-1:0] fb;
    logic [HC-1:0] hb;
    int pc, sc, bst, bsc;
    for (int i = 0; i < FC; i++) fb[i] = (f[i*FB +: FB] >= 4'd8);
    for (int j = 0; j < HC; j++) begin
      pc = 0;
      for (int i = 0; i < FC; i++) if (fb[i] == W1_T[j*FC + i]) pc++;
      hb[j] = (2 * pc >= FC);
    end
    bst = 0;
    bsc = 0;
    for (int k = 0; k < CC; k++) begin
      sc = 0;
      for (int j = 0; j < HC; j++) if (hb[j] == W2_T[k*HC + j]) sc++;
      if (k == 0 || sc > bsc) begin
        bst = k;
        bsc = sc;
      end
    end
    return 4'(bst);
  endfunction

  // Push an expectation whenever the engine accepts a sample.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      sb_q.delete();
    end else if (bus.start === 1'b1 && bus.busy === 1'b0) begin
      e.pred = model(bus.features);
      e.cyc  = cyc;
      sb_q.push_back(e);
    end
  end

  // Pop and compare on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done === 1'b1) begin
      n_done++;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done: done at cycle %0d with no pending sample", cyc);
      end else begin
        e = sb_q.pop_front();
        total++;
        if (bus.prediction !== e.pred) begin
          bad++;
          $display("FAIL sb_prediction: got %0d expected %0d", bus.prediction, e.pred);
        end
        if (cyc - e.cyc != LAT) begin
          bad++;
          $display("FAIL sb_latency: got %0d expected %0d", cyc - e.cyc, LAT);
        end
      end
    end
  end

  task automatic start_pulse(input logic [FC*FB-1:0] f);
    @(negedge clk);
    bus.features = f;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int at);
    int k;
    at = -1;
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        at = cyc;
        break;
      end
      k++;
    end
    total++;
    if (at < 0) begin
      bad++;
      $display("FAIL %s: done not seen within 200 cycles", name);
    end
  endtask

  task automatic test_reset();
    int n0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.features = ALL_0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    total++;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    total++;
    if (bus.prediction !== 4'd0) begin bad++; $display("FAIL reset_pred: got %0d expected 0", bus.prediction); end
    rst = 1'b0;
    n0 = n_done;
    repeat (100) @(negedge clk);
    total++;
    if (n_done != n0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_quiet: dones %0d busy %b expected 0 and 0", n_done - n0, bus.busy);
    end
  endtask

  task automatic run_one(input string name, input logic [FC*FB-1:0] f, input logic [3:0] want);
    int at;
    start_pulse(f);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL %s_busy: got %b expected 1", name, bus.busy); end
    wait_done(name, at);
    total++;
    if (bus.prediction !== want) begin
      bad++;
      $display("FAIL %s_pred: got %0d expected %0d", name, bus.prediction, want);
    end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0 || bus.prediction !== want) begin
      bad++;
      $display("FAIL %s_hold: done %b pred %0d expected 0 and %0d", name, bus.done, bus.prediction, want);
    end
  endtask

  task automatic test_all_ones();
    run_one("all_ones", ALL_F, 4'd3);
  endtask

  task automatic test_tie();
    run_one("tie_low", ALL_0, 4'd0);
  endtask

  task automatic test_threshold();
    // eight features at 8 (majority) vs seven at 8 with the rest at 7
    run_one("thresh_hi", {{8{4'd8}}, {8{4'd7}}}, 4'd3);
    run_one("thresh_lo", {{7{4'd8}}, {9{4'd7}}}, 4'd0);
  endtask

  task automatic test_isolation();
    int n0, at;
    n0 = n_done;
    start_pulse(ALL_F);
    repeat (5) @(negedge clk);
    bus.features = {$urandom, $urandom} & 64'h7777_7777_7777_7777;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (34) @(negedge clk);
    bus.features = {$urandom, $urandom} & 64'h7777_7777_7777_7777;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("isolation", at);
    total++;
    if (bus.prediction !== 4'd3) begin
      bad++;
      $display("FAIL isolation_pred: got %0d expected 3", bus.prediction);
    end
    repeat (60) @(negedge clk);
    total++;
    if (n_done - n0 != 1) begin
      bad++;
      $display("FAIL isolation_count: got %0d done pulses expected 1", n_done - n0);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    start_pulse(ALL_F);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    total++;
    if (bus.prediction !== 4'd0) begin bad++; $display("FAIL midrst_pred: got %0d expected 0", bus.prediction); end
    n0 = n_done;
    repeat (80) @(negedge clk);
    total++;
    if (n_done != n0) begin
      bad++;
      $display("FAIL midrst_nodone: got %0d done pulses expected 0", n_done - n0);
    end
    run_one("midrst_fresh", ALL_F, 4'd3);
  endtask

  task automatic test_back_to_back();
    int t[3];
    @(negedge clk);
    bus.features = ALL_F;
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_done("b2b", t[i]);
      total++;
      if (bus.prediction !== 4'd3) begin
        bad++;
        $display("FAIL b2b_pred: pulse %0d got %0d expected 3", i, bus.prediction);
      end
    end
    bus.start = 1'b0;
    for (int i = 1; i < 3; i++) begin
      total++;
      if (t[i] - t[i-1] != PERIOD) begin
        bad++;
        $display("FAIL b2b_period: got %0d expected %0d", t[i] - t[i-1], PERIOD);
      end
    end
    repeat (60) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_tie();
    test_threshold();
    test_isolation();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bnn_seq_infer_hs.md
Name: bnn_seq_infer_hs

Overview:
- Sequential binarized-neural-network inference engine with a start/done handshake. It is the responder side of the sample-feed protocol the pendigits benches drive.
- Accepts one packed feature vector and binarizes it. Evaluates one hidden neuron per cycle, then one class score per cycle with a running argmax, and returns a class index.
- Replaces fixed reset-and-wait timing with an explicit handshake, so streaming test drivers and SoC wrappers can chain samples back to back.

Parameters:
- FEAT_CNT, 16, number of input features
- FEAT_BITS, 4, bits per feature
- HIDDEN_CNT, 40, hidden neurons
- CLASS_CNT, 10, output classes
- FEAT_THRESH, 8, binarization threshold: bit = (feature >= FEAT_THRESH), unsigned
- W1, 0, packed HIDDEN_CNT*FEAT_CNT weight bits; neuron j occupies bits [j*FEAT_CNT +: FEAT_CNT]
- W2, 0, packed CLASS_CNT*HIDDEN_CNT weight bits; class k occupies bits [k*HIDDEN_CNT +: HIDDEN_CNT]

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- features  in  FEAT_BITS*FEAT_CNT  feature i occupies bits [i*FEAT_BITS +: FEAT_BITS]
- busy  out  1  high in HID, CLS, DONE
- done  out  1  one-cycle pulse, prediction valid
- prediction  out  $clog2(CLASS_CNT)  winning class index

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. On rst: state=IDLE, busy=0, done=0, prediction=0, all counters, latches and score/argmax registers cleared. Reset overrides any state, including mid-run.
- IDLE -> HID when start=1.
  - At that edge, binarize features into fbits[FEAT_CNT] and latch them. Later changes to features are ignored until the next accept.
  - Clear hidden vector hbits and idx.
- HID, HIDDEN_CNT cycles, idx = 0..HIDDEN_CNT-1:
  - pc = popcount(~(fbits ^ W1 row idx))
  - hbits[idx] = (2*pc >= FEAT_CNT)
  - After idx = HIDDEN_CNT-1 -> CLS with idx=0, best=0, best_score=0.
- CLS, CLASS_CNT cycles:
  - score = popcount(~(hbits ^ W2 row idx)), width $clog2(HIDDEN_CNT+1); no overflow is possible.
  - Class 0 unconditionally initializes best and best_score.
  - Afterwards replace only on score > best_score (strict), so ties resolve to the lowest index.
  - After last class -> DONE.
- DONE, 1 cycle: prediction <= best, done=1, busy=1. Next state is IDLE.
- prediction holds its value until the next DONE or reset.
- start in HID/CLS/DONE is ignored, not queued.
- Latency: start accepted at edge E0; done is high in the cycle following edge E0+HIDDEN_CNT+CLASS_CNT+1, i.e. 51 cycles at defaults.
- start held high restarts every HIDDEN_CNT+CLASS_CNT+2 cycles.
- busy=0 only in IDLE.

Decomposition:
- Shared package bnn_pkg holds:
  - state enum (IDLE, HID, CLS, DONE)
  - SUM_BITS = $clog2(HIDDEN_CNT+1) helper
  - class-index width helper
- Natural sub-module: bnn_popcount, a combinational, parameterised-width popcount of an XNOR word.
  - Used once per layer: two instances, or one shared via a mux on width max(FEAT_CNT, HIDDEN_CNT).
- Control FSM, weight-row muxing and argmax stay in the top module.

Test Plan:
- Reset: assert rst 2 cycles -> busy=0, done=0, prediction=0; no done for 100 idle cycles with start=0.
- All-ones path:
  - Setup: W1 all ones; W2 row 3 all ones, other rows zero; features all 0xF.
  - Response: hidden all 1; scores class3=40, others 0; done exactly 51 cycles after accept; prediction=3.
- Tie/lowest index:
  - Setup: same weights, features all 0x0.
  - Response: hidden all 0; class3=0, others 40; prediction=0.
- Input isolation:
  - Stimulus: change features to random values and pulse start during HID and CLS.
  - Response: result identical to the unperturbed run; only one done pulse.
- Reset mid-run: rst at cycle 20 after accept -> busy=0 next cycle, no done, prediction=0; a fresh start yields the correct result.
- Back-to-back: start held high with the all-0xF vector -> done pulses every 52 cycles, prediction=3 each time.
